// File: rtl/rv_instr_encoder_if.sv
// Field-bundle input and encoded-word output channels of rv_instr_encoder.
interface rv_instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// RV32I field-bundle to instruction-word encoder with a sequential word address.
// Optional immediate range checking is enabled by defining RVENC_RANGE_CHECK_EN.
module rv_instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  rv_instr_encoder_if.slave bus,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              err_range
);
  typedef enum logic [3:0] {
    K_LOAD   = 4'd0,
    K_STORE  = 4'd1,
    K_R      = 4'd2,
    K_IALU   = 4'd3,
    K_BRANCH = 4'd4,
    K_JAL    = 4'd5,
    K_LUI    = 4'd6,
    K_AUIPC  = 4'd7
  } kind_e;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  kind_e             kind;
  logic              is_shift;
  logic              illegal;
  logic              in_ready;
  logic              accept;
  logic [31:0]       enc;
  logic [ADDR_W-1:0] addr_base;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  assign kind     = kind_e'(bus.in_kind);
  assign is_shift = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    enc     = '0;
    illegal = 1'b0;
    case (kind)
      K_LOAD:   enc = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0000011};
      K_STORE:  enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       bus.in_imm[4:0], 7'b0100011};
      K_R:      enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd,
                       7'b0110011};
      K_IALU: begin
        if (is_shift)
          enc = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                 7'b0010011};
        else
          enc = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0010011};
      end
      K_BRANCH: enc = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
      K_JAL:    enc = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                       bus.in_rd, 7'b1101111};
      K_LUI:    enc = {bus.in_imm[31:12], bus.in_rd, 7'b0110111};
      K_AUIPC:  enc = {bus.in_imm[31:12], bus.in_rd, 7'b0010111};
      default:  illegal = 1'b1;
    endcase
  end

  // Flush coinciding with an accept rebases that very bundle onto BASE.
  always_comb begin
    addr_base   = flush ? BASE : addr_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    out_addr_d  = out_addr_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      instr_d     = enc;
      out_addr_d  = addr_base;
      addr_d      = addr_base + ADDR_ONE;
      count_d     = flush ? CNT_ONE : ((count_q == '1) ? count_q : count_q + CNT_ONE);
      err_d       = err_q | illegal;
    end else begin
      if (bus.out_ready) out_valid_d = 1'b0;
      if (flush) begin
        addr_d  = BASE;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      out_addr_q  <= BASE;
      addr_q      <= BASE;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      out_addr_q  <= out_addr_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

`ifdef RVENC_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic               range_bad;
  logic               err_range_q, err_range_d;

  assign simm = $signed(bus.in_imm);

  always_comb begin
    range_bad = 1'b0;
    case (kind)
      K_LOAD, K_STORE: range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      K_IALU: begin
        if (is_shift) range_bad = bus.in_imm > 32'd31;
        else          range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      K_BRANCH: range_bad = simm[0] || (simm < -32'sd4096) || (simm > 32'sd4094);
      K_JAL:    range_bad = simm[0] || (simm < -32'sd1048576) || (simm > 32'sd1048574);
      K_LUI, K_AUIPC: range_bad = bus.in_imm[11:0] != '0;
      default:  range_bad = 1'b0;
    endcase
    err_range_d = err_range_q | (accept & range_bad);
  end

  always_ff @(posedge clk) begin
    if (rst) err_range_q <= 1'b0;
    else     err_range_q <= err_range_d;
  end

  assign err_range = err_range_q;
`else
  assign err_range = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = out_addr_q;
  assign count         = count_q;
  assign err           = err_q;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: fixed encoding vectors, handshake/flush/reset corner
// sequences and randomized traffic checked against a cycle-level reference model.
module tb_rv_instr_encoder;
  localparam int unsigned AW    = 2;
  localparam int unsigned BASE  = 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CMAX  = (1 << (AW + 1)) - 1;
`ifdef RVENC_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [AW:0]   count;
  logic          err;
  logic          err_range;

  int checks   = 0;
  int failures = 0;

  bit          m_known = 1'b0;
  logic        m_valid;
  logic [31:0] m_instr;
  int          m_addr, m_ctr, m_cnt;
  logic        m_err, m_erange;

  rv_instr_encoder_if #(.ADDR_W(AW)) bus ();

  rv_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .count     (count),
    .err       (err),
    .err_range (err_range)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(input int kind, input int rd, input int rs1, input int rs2,
                               input int f3, input int f7, input logic [31:0] imm);
    stim_t s;
    s.kind = 4'(kind); s.rd = 5'(rd); s.rs1 = 5'(rs1); s.rs2 = 5'(rs2);
    s.f3 = 3'(f3); s.f7 = 7'(f7); s.imm = imm;
    return s;
  endfunction

  function automatic vec_t mk(input stim_t s, input logic [31:0] exp);
    vec_t v;
    v.s = s; v.exp = exp;
    return v;
  endfunction

  // Reference encoder: fields placed with shifts and masks.
  function automatic logic [31:0] enc_ref(input stim_t s);
    logic [31:0] i, rd, r1, r2, f3, f7;
    i  = s.imm;
    rd = 32'(s.rd) << 7;
    f3 = 32'(s.f3) << 12;
    r1 = 32'(s.rs1) << 15;
    r2 = 32'(s.rs2) << 20;
    f7 = 32'(s.f7) << 25;
    case (s.kind)
      4'd0: return 32'h03 | rd | f3 | r1 | ((i & 32'hFFF) << 20);
      4'd1: return 32'h23 | ((i & 32'h1F) << 7) | f3 | r1 | r2 | (((i >> 5) & 32'h7F) << 25);
      4'd2: return 32'h33 | rd | f3 | r1 | r2 | f7;
      4'd3: begin
        if (s.f3 == 3'd1 || s.f3 == 3'd5) return 32'h13 | rd | f3 | r1 | ((i & 32'h1F) << 20) | f7;
        return 32'h13 | rd | f3 | r1 | ((i & 32'hFFF) << 20);
      end
      4'd4: return 32'h63 | (((i >> 11) & 1) << 7) | (((i >> 1) & 15) << 8) | f3 | r1 | r2 |
                   (((i >> 5) & 63) << 25) | (((i >> 12) & 1) << 31);
      4'd5: return 32'h6F | rd | (((i >> 12) & 255) << 12) | (((i >> 11) & 1) << 20) |
                   (((i >> 1) & 1023) << 21) | (((i >> 20) & 1) << 31);
      4'd6: return 32'h37 | rd | (i & 32'hFFFFF000);
      4'd7: return 32'h17 | rd | (i & 32'hFFFFF000);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit range_ref(input stim_t s);
    int v;
    bit bad;
    v   = signed'(s.imm);
    bad = 1'b0;
    case (s.kind)
      4'd0, 4'd1: bad = (v < -2048) || (v > 2047);
      4'd3: begin
        if (s.f3 == 3'd1 || s.f3 == 3'd5) bad = (v < 0) || (v > 31);
        else                              bad = (v < -2048) || (v > 2047);
      end
      4'd4: bad = ((v % 2) != 0) || (v < -4096) || (v > 4094);
      4'd5: bad = ((v % 2) != 0) || (v < -(1 << 20)) || (v > (1 << 20) - 2);
      4'd6, 4'd7: bad = (s.imm & 32'hFFF) != 0;
      default: bad = 1'b0;
    endcase
    return RC_EN && bad;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: apply inputs at negedge, step the model, check outputs at next negedge.
  task automatic drive(input stim_t s, input logic v, input logic ordy, input logic fl,
                       input logic r);
    logic rdy;
    int   base;
    bus.in_valid = v;     bus.in_kind = s.kind; bus.in_rd = s.rd; bus.in_rs1 = s.rs1;
    bus.in_rs2 = s.rs2;   bus.in_funct3 = s.f3; bus.in_funct7 = s.f7; bus.in_imm = s.imm;
    bus.out_ready = ordy; flush = fl;           rst = r;
    #1;
    rdy = !m_valid || ordy;
    if (m_known) chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    if (r) begin
      m_known = 1'b1; m_valid = 1'b0; m_instr = '0; m_addr = BASE; m_ctr = BASE;
      m_cnt = 0; m_err = 1'b0; m_erange = 1'b0;
    end else if (m_known) begin
      if (v && rdy) begin
        base    = fl ? BASE : m_ctr;
        m_instr = enc_ref(s);
        m_addr  = base;
        m_ctr   = (base + 1) % DEPTH;
        m_cnt   = fl ? 1 : ((m_cnt == CMAX) ? m_cnt : m_cnt + 1);
        m_valid = 1'b1;
        if (s.kind > 4'd7) m_err = 1'b1;
        if (range_ref(s)) m_erange = 1'b1;
      end else begin
        if (ordy) m_valid = 1'b0;
        if (fl) begin
          m_ctr = BASE;
          m_cnt = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (m_known) begin
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("out_instr", 64'(bus.out_instr), 64'(m_instr));
      chk("out_addr",  64'(bus.out_addr),  64'(m_addr));
      chk("count",     64'(count),         64'(m_cnt));
      chk("err",       64'(err),           64'(m_err));
      chk("err_range", 64'(err_range),     64'(m_erange));
    end
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    s.kind = ($urandom % 8 == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
    s.rd = 5'($urandom); s.rs1 = 5'($urandom); s.rs2 = 5'($urandom);
    s.f3 = 3'($urandom); s.f7 = 7'($urandom);
    case ($urandom % 4)
      0: s.imm = $urandom;
      1: s.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: s.imm = 32'($urandom_range(0, 63)) - 32'd32;
      default: s.imm = $urandom & 32'hFFFFF000;
    endcase
    return s;
  endfunction

  vec_t  tab [10];
  stim_t idle;

  initial begin
    idle = st(0, 0, 0, 0, 0, 0, 32'h0);
    tab[0] = mk(st(0, 5, 2, 0, 2, 0, 32'd8),          32'h00812283);
    tab[1] = mk(st(2, 3, 1, 2, 0, 0, 32'd0),          32'h002081B3);
    tab[2] = mk(st(4, 0, 1, 2, 0, 0, -32'sd4),        32'hFE208EE3);
    tab[3] = mk(st(5, 1, 0, 0, 0, 0, 32'd8),          32'h008000EF);
    tab[4] = mk(st(1, 0, 2, 5, 2, 0, 32'd12),         32'h00512623);
    tab[5] = mk(st(6, 10, 0, 0, 0, 0, 32'h12345000),  32'h12345537);
    tab[6] = mk(st(7, 1, 0, 0, 0, 0, 32'h00001000),   32'h00001097);
    tab[7] = mk(st(3, 3, 4, 0, 5, 7'h20, 32'd5),      32'h40525193);
    tab[8] = mk(st(3, 1, 0, 0, 0, 0, 32'hFFFFFFFF),   32'hFFF00093);
    tab[9] = mk(st(15, 7, 7, 7, 7, 7'h7F, 32'hFFFF),  32'h00000000);

    @(negedge clk);
    drive(idle, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(idle, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_out_addr",  64'(bus.out_addr),  64'(BASE));
    chk("rst_count",     64'(count),         64'd0);

    // Encoding table, back-to-back; address wraps after DEPTH entries.
    for (int i = 0; i < 10; i++) begin
      drive(tab[i].s, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("tab_instr", 64'(bus.out_instr), 64'(tab[i].exp));
      chk("tab_addr",  64'(bus.out_addr),  64'((BASE + i) % DEPTH));
      chk("tab_count", 64'(count),         64'((i + 1 > CMAX) ? CMAX : i + 1));
    end
    chk("err_illegal", 64'(err), 64'd1);
    drive(tab[0].s, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("err_sticky", 64'(err), 64'd1);

    // Backpressure: bundle tab[1] waits three cycles behind tab[0].
    drive(tab[0].s, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(tab[1].s, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_hold",     64'(bus.out_instr), 64'(tab[0].exp));
    end
    drive(tab[1].s, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("bp_release", 64'(bus.out_instr), 64'(tab[1].exp));

    // Flush while the output is stalled: held word untouched, sequence restarts.
    drive(tab[2].s, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("flush_hold",  64'(bus.out_instr), 64'(tab[1].exp));
    chk("flush_count", 64'(count), 64'd0);
    drive(tab[3].s, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("flush_next_addr", 64'(bus.out_addr), 64'(BASE));
    chk("flush_next_cnt",  64'(count), 64'd1);
    drive(tab[4].s, 1'b1, 1'b1, 1'b0, 1'b0);

    // Flush together with an accept.
    drive(tab[5].s, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flacc_addr",  64'(bus.out_addr), 64'(BASE));
    chk("flacc_count", 64'(count), 64'd1);
    drive(tab[6].s, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("flacc_next",  64'(bus.out_addr), 64'((BASE + 1) % DEPTH));

    // Count saturation.
    drive(idle, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < int'(CMAX) + 3; i++) drive(tab[i % 9].s, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("count_sat", 64'(count), 64'(CMAX));

    // Reset with a stalled word in flight.
    drive(tab[7].s, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(tab[8].s, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_instr", 64'(bus.out_instr), 64'd0);
    chk("mid_rst_err",   64'(err), 64'd0);

    // Immediate range flags.
    drive(st(3, 1, 1, 0, 0, 0, 32'd2048), 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rng_ialu", 64'(err_range), 64'(RC_EN));
    chk("rng_ialu_trunc", 64'(bus.out_instr), 64'h80008093);
    drive(idle, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(st(4, 0, 1, 2, 0, 0, 32'd3), 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rng_branch", 64'(err_range), 64'(RC_EN));
    drive(tab[0].s, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rng_sticky", 64'(err_range), 64'(RC_EN));

    // Randomized traffic against the model.
    drive(idle, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 500; n++) begin
      drive(rnd_stim(), 1'($urandom % 4 != 0), 1'($urandom % 4 != 0),
            1'($urandom % 16 == 0), 1'($urandom % 64 == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
